// File: rtl/oled_pkg.sv
// Shared OLED geometry, FSM encoding and pixel-address helper for the framebuffer write path.
package oled_pkg;

  localparam int OLED_W  = 96;
  localparam int OLED_H  = 64;
  localparam int PX_W    = 13;
  localparam int COLOR_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
  localparam logic [1:0] ST_REJECT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [7:0] x1;
    logic [7:0] y1;
    logic [7:0] x2;
    logic [7:0] y2;
    logic [7:0] th;
  } box_t;

  // y*96 built as y*64 + y*32 so no multiplier is needed.
  function automatic logic [PX_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    logic [PX_W-1:0] yw;
    logic [PX_W-1:0] xw;
    yw = {{(PX_W-8){1'b0}}, y};
    xw = {{(PX_W-8){1'b0}}, x};
    return (yw << 6) + (yw << 5) + xw;
  endfunction

endpackage

// File: rtl/box_border_cursor.sv
// Combinational raster step over a box outline: next cursor and last-pixel flag.
// Jumps over the interior of rows that are not inside the top/bottom border bands.
module box_border_cursor
  import oled_pkg::*;
(
  input  logic [7:0] cx_i,
  input  logic [7:0] cy_i,
  input  box_t       box_i,
  output logic [7:0] cx_o,
  output logic [7:0] cy_o,
  output logic       last_o
);

  logic [7:0] dy_top;
  logic [7:0] dy_bot;
  logic       interior_row;
  logic       wide;
  logic [8:0] skip_col;

  assign dy_top       = cy_i - box_i.y1;
  assign dy_bot       = box_i.y2 - cy_i;
  assign interior_row = (dy_top >= box_i.th) && (dy_bot >= box_i.th);
  // Only rows wider than both side bands together have a gap to skip.
  assign wide         = ({1'b0, box_i.x2 - box_i.x1} + 9'd1) > {box_i.th, 1'b0};
  assign skip_col     = {1'b0, box_i.x1} + {1'b0, box_i.th} - 9'd1;

  always_comb begin
    cx_o = cx_i + 8'd1;
    cy_o = cy_i;
    if (interior_row && wide && ({1'b0, cx_i} == skip_col)) begin
      cx_o = box_i.x2 - box_i.th + 8'd1;
    end else if (cx_i == box_i.x2) begin
      cx_o = box_i.x1;
      cy_o = cy_i + 8'd1;
    end
  end

  assign last_o = (cx_i == box_i.x2) && (cy_i == box_i.y2);

endmodule

// File: rtl/box_outline_writer.sv
// Walks a rectangle outline in raster order, one framebuffer write per border pixel.
// First write one cycle after start; wr_ready low freezes cursor, address and data.
module box_outline_writer
  import oled_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         x1,
  input  logic [7:0]         y1,
  input  logic [7:0]         x2,
  input  logic [7:0]         y2,
  input  logic [7:0]         th,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [PX_W-1:0]    wr_addr,
  output logic [COLOR_W-1:0] wr_data
);

  localparam logic [7:0] W8 = 8'(OLED_W);
  localparam logic [7:0] H8 = 8'(OLED_H);

  logic [1:0]         state_q, state_d;
  box_t               box_q, box_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [7:0]         cx_q, cx_d, cy_q, cy_d;
  logic [7:0]         cx_nxt, cy_nxt;
  logic               last_px;
  logic               req_bad;
  box_t               req;

  assign req     = {x1, y1, x2, y2, th};
  assign req_bad = (x1 > x2) || (y1 > y2) || (x2 >= W8) || (y2 >= H8) || (th == 8'd0);

  box_border_cursor u_cursor (
    .cx_i   (cx_q),
    .cy_i   (cy_q),
    .box_i  (box_q),
    .cx_o   (cx_nxt),
    .cy_o   (cy_nxt),
    .last_o (last_px)
  );

  always_comb begin
    state_d = state_q;
    box_d   = box_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          box_d   = req;
          color_d = color;
          cx_d    = x1;
          cy_d    = y1;
          state_d = req_bad ? ST_REJECT : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (wr_ready) begin
          if (last_px) begin
            state_d = ST_DONE;
          end else begin
            cx_d = cx_nxt;
            cy_d = cy_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      box_q   <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      box_q   <= box_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  assign busy     = (state_q == ST_EMIT);
  assign wr_valid = (state_q == ST_EMIT);
  assign done     = (state_q == ST_REJECT) || (state_q == ST_DONE);
  assign err      = (state_q == ST_REJECT);
  assign wr_addr  = pix_addr(cx_q, cy_q);
  assign wr_data  = color_q;

endmodule

// File: tb/tb_box_outline_writer.sv
// Randomised bench for box_outline_writer against a brute-force per-pixel box model.
module tb_box_outline_writer;
  import oled_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x1 = '0, y1 = '0, x2 = '0, y2 = '0, th = '0;
  logic [15:0] color = '0;
  logic        busy, done, err, wr_valid;
  logic        wr_ready = 1'b1;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;

  box_outline_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .th(th), .color(color),
    .busy(busy), .done(done), .err(err), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: scan the whole screen and keep every pixel a per-pixel box test marks.
  int model_q[$];
  function automatic void build_model(input int bx1, input int by1, input int bx2, input int by2, input int bth);
    model_q.delete();
    for (int y = 0; y < OLED_H; y++)
      for (int x = 0; x < OLED_W; x++)
        if (x >= bx1 && x <= bx2 && y >= by1 && y <= by2 &&
            (y - by1 < bth || by2 - y < bth || x - bx1 < bth || bx2 - x < bth))
          model_q.push_back(y * OLED_W + x);
  endfunction

  function automatic bit req_bad(input int bx1, input int by1, input int bx2, input int by2, input int bth);
    return (bx1 > bx2) || (by1 > by2) || (bx2 >= OLED_W) || (by2 >= OLED_H) || (bth == 0);
  endfunction

  int          exp_q[$];
  logic [15:0] exp_color;
  bit          exp_err;
  bit          chk_en = 0;
  bit          done_flag;
  bit          expect_done;
  int          done_cyc;
  int          hs_cnt;
  int          rdy_mode;
  int          stall_left;

  // Compare process: checks outputs, then chooses wr_ready for the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (wr_valid) begin
        check("busy_with_valid", busy, 1);
        if (exp_q.size() == 0) begin
          check("spurious_write", wr_valid, 0);
        end else begin
          check("wr_addr", wr_addr, exp_q[0]);
          check("wr_data", wr_data, exp_color);
        end
      end
      if (done) begin
        check("done_err", err, exp_err);
        if (!exp_err) check("done_timing", expect_done, 1);
        done_flag = 1;
        done_cyc  = cyc;
      end else if (expect_done) begin
        check("done_missing", done, 1);
      end
      expect_done = 0;
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (wr_valid && hs_cnt == 4 && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
          end else begin
            wr_ready = 1'b1;
          end
        end
      endcase
      if (wr_valid && wr_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs_cnt++;
        if (exp_q.size() == 0) expect_done = 1;
      end
    end
  end

  task automatic arm(input int a, input int b, input int c, input int d, input int t,
                     input logic [15:0] col, input int mode);
    build_model(a, b, c, d, t);
    exp_err = req_bad(a, b, c, d, t);
    exp_q   = model_q;
    if (exp_err) exp_q.delete();
    exp_color   = col;
    rdy_mode    = mode;
    stall_left  = 3;
    hs_cnt      = 0;
    done_flag   = 0;
    expect_done = 0;
  endtask

  task automatic issue(input int a, input int b, input int c, input int d, input int t,
                       input logic [15:0] col, input int mode);
    x1 = 8'(a); y1 = 8'(b); x2 = 8'(c); y2 = 8'(d); th = 8'(t); color = col;
    if (mode != 1) wr_ready = 1'b1;
    start  = 1'b1;
    chk_en = 1;
  endtask

  task automatic run_job(input int a, input int b, input int c, input int d, input int t,
                         input logic [15:0] col, input int mode, input bit poke);
    int n, start_cyc, budget;
    arm(a, b, c, d, t, col, mode);
    n = exp_q.size();
    @(negedge clk);
    issue(a, b, c, d, t, col, mode);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    {x1, y1, x2, y2, th} = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    color = 16'($urandom);
    check("first_valid", wr_valid, !exp_err);
    check("accept_busy", busy, !exp_err);
    check("accept_done", done, exp_err);
    budget = n * 8 + 20;
    for (int i = 0; i < budget && !done_flag; i++) begin
      @(negedge clk);
      start = poke && (i == 1);
      if (poke && i == 1) {x1, y1, x2, y2, th} = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    end
    start = 1'b0;
    check("done_seen", done_flag, 1);
    check("writes_left", exp_q.size(), 0);
    if (exp_err)        check("reject_latency", done_cyc - start_cyc, 1);
    else if (mode == 0) check("done_latency", done_cyc - start_cyc, n + 1);
    else if (mode == 2 && n > 4) check("stall_latency", done_cyc - start_cyc, n + 4);
    @(negedge clk);
    check("idle_after", busy | wr_valid | done, 0);
    chk_en = 0;
  endtask

  int pin[10] = '{290, 291, 292, 293, 386, 389, 482, 483, 484, 485};

  initial begin
    // Reset state, with start asserted during reset: reset must win.
    start = 1'b1; x1 = 8'd1; y1 = 8'd1; x2 = 8'd4; y2 = 8'd4; th = 8'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", wr_valid, 0);

    // Pin the model itself to hand-computed pixel lists.
    build_model(2, 3, 5, 5, 1);
    check("model_small_n", model_q.size(), 10);
    for (int i = 0; i < 10 && i < model_q.size(); i++) check("model_small_addr", model_q[i], pin[i]);
    build_model(0, 0, 3, 3, 2);
    check("model_solid_n", model_q.size(), 16);
    build_model(0, 0, 95, 63, 1);
    check("model_full_n", model_q.size(), 316);
    check("model_full_first", model_q[0], 0);
    check("model_full_row1a", model_q[96], 96);
    check("model_full_row1b", model_q[97], 191);
    check("model_full_last", model_q[315], 6143);

    run_job(2, 3, 5, 5, 1, 16'hF800, 0, 0);
    run_job(2, 3, 5, 5, 1, 16'h07E0, 2, 0);
    run_job(10, 0, 5, 5, 1, 16'h001F, 0, 0);
    run_job(0, 0, 3, 3, 2, 16'h1234, 0, 0);
    run_job(0, 0, 95, 63, 1, 16'hFFFF, 0, 1);
    run_job(7, 7, 7, 7, 3, 16'hAAAA, 0, 0);
    run_job(10, 20, 40, 20, 2, 16'h5555, 1, 0);
    run_job(30, 5, 30, 40, 1, 16'h0F0F, 1, 0);
    run_job(1, 1, 20, 9, 3, 16'hBEEF, 1, 1);
    run_job(0, 0, 96, 10, 1, 16'h0001, 0, 0);
    run_job(0, 0, 10, 64, 1, 16'h0002, 0, 0);
    run_job(3, 3, 9, 9, 0, 16'h0003, 0, 0);

    // Reset mid-outline: outline abandoned, no done pulse, then a clean restart.
    arm(0, 0, 95, 63, 1, 16'hCAFE, 0);
    @(negedge clk);
    issue(0, 0, 95, 63, 1, 16'hCAFE, 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 4; i++) @(negedge clk);
    chk_en = 0;
    check("hs_before_rst", hs_cnt >= 4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", wr_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", wr_valid | done | busy, 0);
    run_job(2, 3, 5, 5, 1, 16'h4321, 0, 0);

    for (int k = 0; k < 25; k++) begin
      int a, b, c, d, t;
      bit pk;
      a = $urandom_range(0, 95);
      c = a + $urandom_range(0, 20);
      b = $urandom_range(0, 63);
      d = b + $urandom_range(0, 12);
      t = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) begin
        int tmp;
        tmp = a; a = c + 1; c = tmp;
      end
      build_model(a, b, c, d, t);
      pk = !req_bad(a, b, c, d, t) && (model_q.size() > 12);
      run_job(a, b, c, d, t, 16'($urandom), 1, pk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
